// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared Hamming(12,8) types, widths and syndrome/class helpers
//
// Purpose : common definitions for the receive-side Hamming(12,8) check path.
//           Holds the error class enum, codeword/data/syndrome widths and
//           helper functions for the syndrome, error class and data extraction.
// Ports   : none (package)
package ecc_pkg;

    localparam int CW_W   = 12;
    localparam int DATA_W = 8;
    localparam int SYN_W  = 4;

    typedef enum logic [1:0] {
        CLEAN   = 2'd0,
        PARITY  = 2'd1,
        DATA    = 2'd2,
        INVALID = 2'd3
    } ecc_class_t;

    // Codeword bit k-1 holds Hamming position k. Each syndrome bit covers the
    // positions whose index has that bit set.
    function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
        logic [SYN_W-1:0] s;
        s[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10];
        s[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10];
        s[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6] ^ cw[11];
        s[3] = cw[7] ^ cw[8] ^ cw[9] ^ cw[10] ^ cw[11];
        return s;
    endfunction

    // Syndromes naming a check-bit position are PARITY, those naming a data
    // position are DATA, and 13..15 point outside the 12-bit word.
    function automatic ecc_class_t classify(input logic [SYN_W-1:0] syn);
        ecc_class_t c;
        case (syn)
            4'd0:                         c = CLEAN;
            4'd1, 4'd2, 4'd4, 4'd8:       c = PARITY;
            4'd13, 4'd14, 4'd15:          c = INVALID;
            default:                      c = DATA;
        endcase
        return c;
    endfunction

    // Data bits live at positions 3,5,6,7,9,10,11,12 (D0..D7).
    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        return {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
    endfunction

endpackage

// File: rtl/ecc_cnt_sat.sv
// rtl/ecc_cnt_sat.sv - saturating event counter with clear priority
//
// Purpose : counts increment requests and sticks at all-ones; a clear in the
//           same cycle as an increment wins.
// Ports   : clk   - clock, rising edge
//           rst   - asynchronous active-high reset
//           i_inc - count one event this cycle
//           i_clr - synchronous clear (priority over i_inc)
//           o_cnt - current count
module ecc_cnt_sat #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = &r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ecc_syndrome_stage.sv
// rtl/ecc_syndrome_stage.sv - Hamming(12,8) syndrome check stage, 2-stage pipeline
//
// Purpose : accepts 12-bit codewords, registers them (S1), computes the syndrome
//           and error class from the S1 register and captures data/syndrome/class
//           into the output register (S2). Keeps saturating error counters and a
//           sticky error flag updated on delivered results.
// Ports   : clk, reset              - clock / asynchronous active-high reset
//           in_valid/in_ready/in_cw - codeword input handshake
//           out_valid/out_ready     - result output handshake
//           out_data                - raw data byte D7..D0
//           out_syn                 - {4'b0, S8,S4,S2,S1} mask source for the decoder
//           out_class               - CLEAN/PARITY/DATA/INVALID
//           clr_cnt                 - clears counters and sticky flag
//           cnt_corr, cnt_bad       - delivered PARITY|DATA / INVALID counts
//           err_sticky              - any non-CLEAN result delivered
module ecc_syndrome_stage
    import ecc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [7:0]       out_syn,
    output logic [1:0]       out_class,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_bad,
    output logic             err_sticky
);

    // Ready is held low while in reset and until the first clock after it.
    logic              r_rdy_en;
    logic              r_s1_valid;
    logic [CW_W-1:0]   r_s1_cw;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SYN_W-1:0]  r_out_syn;
    ecc_class_t        r_out_class;
    logic              r_sticky;

    logic              w_s2_adv;
    logic              w_in_ready;
    logic              w_out_hs;
    logic [SYN_W-1:0]  w_s1_syn;
    ecc_class_t        w_s1_class;
    logic [DATA_W-1:0] w_s1_data;
    logic              w_inc_corr;
    logic              w_inc_bad;

    assign w_s1_syn   = calc_syndrome(r_s1_cw);
    assign w_s1_class = classify(w_s1_syn);
    assign w_s1_data  = extract_data(r_s1_cw);

    // S2 may load whenever it is empty or its result leaves this cycle; S1 may
    // load when it is empty or drains into S2. This is the only out->in path.
    assign w_s2_adv   = !r_out_valid || out_ready;
    assign w_in_ready = r_rdy_en && (!r_s1_valid || w_s2_adv);
    assign w_out_hs   = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy_en    <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_cw     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_syn   <= '0;
            r_out_class <= CLEAN;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_cw <= in_cw;
                end
            end
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data  <= w_s1_data;
                    r_out_syn   <= w_s1_syn;
                    r_out_class <= w_s1_class;
                end
            end
        end
    end

    assign w_inc_corr = w_out_hs && ((r_out_class == PARITY) || (r_out_class == DATA));
    assign w_inc_bad  = w_out_hs && (r_out_class == INVALID);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= 1'b0;
        end else if (clr_cnt) begin
            r_sticky <= 1'b0;
        end else if (w_out_hs && (r_out_class != CLEAN)) begin
            r_sticky <= 1'b1;
        end
    end

    ecc_cnt_sat #(.CNT_W(CNT_W)) u_cnt_corr (
        .clk   (clk),
        .rst   (reset),
        .i_inc (w_inc_corr),
        .i_clr (clr_cnt),
        .o_cnt (cnt_corr)
    );

    ecc_cnt_sat #(.CNT_W(CNT_W)) u_cnt_bad (
        .clk   (clk),
        .rst   (reset),
        .i_inc (w_inc_bad),
        .i_clr (clr_cnt),
        .o_cnt (cnt_bad)
    );

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_syn    = {4'b0000, r_out_syn};
    assign out_class  = r_out_class;
    assign err_sticky = r_sticky;

endmodule

// File: tb/tb_ecc_syndrome_stage.sv
// tb/tb_ecc_syndrome_stage.sv - self-checking bench for ecc_syndrome_stage
module tb_ecc_syndrome_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [11:0] in_cw;
    logic        out_ready;
    logic        clr_cnt;

    logic        in_ready, out_valid, err_sticky;
    logic [7:0]  out_data, out_syn;
    logic [1:0]  out_class;
    logic [15:0] cnt_corr, cnt_bad;

    logic        in_ready2, out_valid2, err_sticky2;
    logic [7:0]  out_data2, out_syn2;
    logic [1:0]  out_class2;
    logic [1:0]  cnt_corr2, cnt_bad2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ecc_syndrome_stage #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_syn(out_syn),
        .out_class(out_class), .clr_cnt(clr_cnt), .cnt_corr(cnt_corr), .cnt_bad(cnt_bad),
        .err_sticky(err_sticky)
    );

    ecc_syndrome_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in_cw(in_cw),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_syn(out_syn2),
        .out_class(out_class2), .clr_cnt(clr_cnt), .cnt_corr(cnt_corr2), .cnt_bad(cnt_bad2),
        .err_sticky(err_sticky2)
    );

    // Reference model: a single-bit error at position k yields syndrome k, so
    // the syndrome is the XOR of the positions of all set bits.
    function automatic int model_syn(input logic [11:0] cw);
        int s = 0;
        for (int k = 1; k <= 12; k++) if (cw[k-1]) s = s ^ k;
        return s;
    endfunction

    function automatic logic [1:0] model_class(input int s);
        if (s == 0) return 2'd0;
        if (s == 1 || s == 2 || s == 4 || s == 8) return 2'd1;
        if (s <= 12) return 2'd2;
        return 2'd3;
    endfunction

    function automatic bit is_pow2(input int k);
        return (k & (k - 1)) == 0;
    endfunction

    function automatic logic [7:0] model_data(input logic [11:0] cw);
        logic [7:0] d = '0;
        int n = 0;
        for (int k = 1; k <= 12; k++) if (!is_pow2(k)) begin d[n] = cw[k-1]; n++; end
        return d;
    endfunction

    function automatic logic [11:0] encode(input logic [7:0] d);
        logic [11:0] cw = '0;
        int n = 0;
        int s;
        for (int k = 1; k <= 12; k++) if (!is_pow2(k)) begin cw[k-1] = d[n]; n++; end
        s = model_syn(cw);
        for (int b = 0; b < 4; b++) if (s[b]) cw[(1 << b) - 1] = 1'b1;
        return cw;
    endfunction

    // Downstream decoder: syndrome naming a data position flips that data bit.
    function automatic logic [7:0] model_mask(input int s);
        logic [7:0] m = '0;
        int n = 0;
        for (int k = 1; k <= 12; k++) if (!is_pow2(k)) begin if (k == s) m[n] = 1'b1; n++; end
        return m;
    endfunction

    task automatic xfer(input logic [11:0] cw, output logic [7:0] d, output logic [7:0] sy,
                        output logic [1:0] c, output bit ok);
        int n;
        ok = 0; d = '0; sy = '0; c = '0;
        @(negedge clk);
        in_valid = 1'b1; in_cw = cw; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 10) begin @(negedge clk); #1; n++; end
        if (!in_ready) begin in_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n = 0;
        while (!out_valid && n < 10) begin @(negedge clk); #1; n++; end
        if (out_valid) begin d = out_data; sy = out_syn; c = out_class; ok = 1; end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [7:0] d, sy; logic [1:0] c; bit ok;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %0b want 1", in_ready); end
        xfer(12'h001, d, sy, c, ok);
        checks++; if (cnt_corr !== 16'd1) begin errors++; $display("FAIL reset_precount: got %0d want 1", cnt_corr); end
        @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_cw = 12'h123;
        @(posedge clk); @(negedge clk); in_cw = 12'h456;
        @(posedge clk); @(negedge clk); in_cw = 12'h789;
        @(posedge clk); @(negedge clk);
        reset = 1'b1; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        checks++; if (cnt_corr !== 16'd0 || cnt_bad !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cnt_corr, cnt_bad); end
        checks++; if (out_data !== 8'd0 || out_syn !== 8'd0 || out_class !== 2'd0 || err_sticky !== 1'b0)
            begin errors++; $display("FAIL reset_outputs: got data=%h syn=%h cls=%0d sticky=%0b want 0", out_data, out_syn, out_class, err_sticky); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_release: got %0b want 1", in_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_dropped: got out_valid=%0b want 0", out_valid); end
    endtask

    task automatic test_clean;
        logic [11:0] cws [2];
        logic [7:0]  exp_d [2];
        cws[0] = 12'h000;      exp_d[0] = 8'h00;
        cws[1] = encode(8'hA5); exp_d[1] = 8'hA5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); in_valid = 1'b1; in_cw = cws[i]; out_ready = 1'b1; #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clean_in_ready[%0d]: got %0b want 1", i, in_ready); end
            @(posedge clk); @(negedge clk); in_valid = 1'b0; #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_latency_early[%0d]: got %0b want 0", i, out_valid); end
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_latency[%0d]: got %0b want 1", i, out_valid); end
            checks++; if (out_syn !== 8'h00 || out_class !== 2'd0 || out_data !== exp_d[i])
                begin errors++; $display("FAIL clean_result[%0d]: got syn=%h cls=%0d data=%h want 00/0/%h", i, out_syn, out_class, out_data, exp_d[i]); end
            @(posedge clk);
        end
    endtask

    task automatic test_single_errors;
        logic [11:0] base, flip;
        logic [7:0]  d, sy, esy;
        logic [1:0]  c, ec;
        bit ok;
        base = encode(8'h3C);
        for (int p = 1; p <= 12; p++) begin
            flip = '0; flip[p-1] = 1'b1;
            xfer(base ^ flip, d, sy, c, ok);
            esy = 8'(p);
            ec  = is_pow2(p) ? 2'd1 : 2'd2;
            checks++; if (!ok) begin errors++; $display("FAIL single_timeout[%0d]: no result within bound", p); end
            checks++; if (sy !== esy || c !== ec) begin errors++; $display("FAIL single_syn[%0d]: got syn=%0d cls=%0d want %0d/%0d", p, sy, c, esy, ec); end
            checks++; if ((model_mask(int'(sy[3:0])) ^ d) !== 8'h3C) begin errors++; $display("FAIL single_corrected[%0d]: got %h want 3c", p, model_mask(int'(sy[3:0])) ^ d); end
        end
        checks++; if (cnt_corr !== 16'd12) begin errors++; $display("FAIL single_cnt_corr: got %0d want 12", cnt_corr); end
        checks++; if (cnt_corr2 !== 2'd3) begin errors++; $display("FAIL single_cnt_corr_sat: got %0d want 3", cnt_corr2); end
        checks++; if (err_sticky !== 1'b1 || cnt_bad !== 16'd0) begin errors++; $display("FAIL single_sticky: got sticky=%0b bad=%0d want 1/0", err_sticky, cnt_bad); end
    endtask

    task automatic test_invalid;
        logic [7:0] d, sy; logic [1:0] c; bit ok;
        xfer(12'h801, d, sy, c, ok);
        checks++; if (!ok || sy !== 8'd13 || c !== 2'd3) begin errors++; $display("FAIL invalid_result: got ok=%0b syn=%0d cls=%0d want 1/13/3", ok, sy, c); end
        checks++; if (cnt_bad !== 16'd1 || cnt_corr !== 16'd12 || err_sticky !== 1'b1)
            begin errors++; $display("FAIL invalid_counters: got bad=%0d corr=%0d sticky=%0b want 1/12/1", cnt_bad, cnt_corr, err_sticky); end
    endtask

    task automatic test_backpressure;
        logic [11:0] q_cw [$];
        logic [11:0] pend, exp_cw;
        int sent = 0, got = 0, occ = 0, cyc = 0;
        bit p_stall = 0, in_hs, out_hs;
        logic [7:0] p_d, p_s; logic [1:0] p_c;
        pend = 12'($urandom);
        while (got < 8 && cyc < 300) begin
            @(negedge clk);
            in_valid  = (sent < 8) && ($urandom_range(0, 3) != 0);
            in_cw     = pend;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            checks++; if (in_ready !== ((occ < 2) || out_ready)) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %0b want %0b (occ=%0d)", cyc, in_ready, (occ < 2) || out_ready, occ); end
            if (p_stall) begin
                checks++; if (out_valid !== 1'b1 || out_data !== p_d || out_syn !== p_s || out_class !== p_c)
                    begin errors++; $display("FAIL bp_stable cyc%0d: got v=%0b %h/%h/%0d want 1 %h/%h/%0d", cyc, out_valid, out_data, out_syn, out_class, p_d, p_s, p_c); end
            end
            in_hs  = in_valid && in_ready;
            out_hs = out_valid && out_ready;
            if (out_hs) begin
                if (q_cw.size() == 0) begin
                    checks++; errors++; $display("FAIL bp_extra cyc%0d: got unexpected word data=%h want none", cyc, out_data);
                end else begin
                    exp_cw = q_cw.pop_front();
                    checks++; if (out_data !== model_data(exp_cw) || out_syn !== 8'(model_syn(exp_cw)) || out_class !== model_class(model_syn(exp_cw)))
                        begin errors++; $display("FAIL bp_word%0d: got %h/%h/%0d want %h/%h/%0d", got, out_data, out_syn, out_class,
                              model_data(exp_cw), 8'(model_syn(exp_cw)), model_class(model_syn(exp_cw))); end
                end
                got++;
            end
            if (in_hs) begin q_cw.push_back(pend); sent++; pend = 12'($urandom); end
            occ = occ + int'(in_hs) - int'(out_hs);
            p_stall = out_valid && !out_ready;
            p_d = out_data; p_s = out_syn; p_c = out_class;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 8 || q_cw.size() != 0) begin errors++; $display("FAIL bp_complete: got %0d words (%0d pending) want 8 (0)", got, q_cw.size()); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_counters;
        logic [7:0] d, sy; logic [1:0] c; bit ok;
        logic [11:0] flip;
        @(negedge clk); clr_cnt = 1'b1;
        @(posedge clk); @(negedge clk); clr_cnt = 1'b0; #1;
        checks++; if (cnt_corr !== 16'd0 || cnt_bad !== 16'd0 || err_sticky !== 1'b0 || cnt_corr2 !== 2'd0)
            begin errors++; $display("FAIL cnt_clear: got %0d/%0d/%0b/%0d want 0/0/0/0", cnt_corr, cnt_bad, err_sticky, cnt_corr2); end
        flip = 12'h004;
        for (int i = 0; i < 5; i++) xfer(encode(8'($urandom)) ^ flip, d, sy, c, ok);
        checks++; if (cnt_corr2 !== 2'd3 || err_sticky2 !== 1'b1) begin errors++; $display("FAIL cnt_saturate: got %0d sticky=%0b want 3/1", cnt_corr2, err_sticky2); end
        checks++; if (cnt_corr !== 16'd5) begin errors++; $display("FAIL cnt_wide: got %0d want 5", cnt_corr); end
        @(negedge clk); in_valid = 1'b1; in_cw = encode(8'h5A) ^ 12'h010; out_ready = 1'b0;
        @(posedge clk); @(negedge clk); in_valid = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL cnt_stall_setup: got out_valid=%0b want 1", out_valid); end
        out_ready = 1'b1; clr_cnt = 1'b1;
        @(posedge clk); @(negedge clk); clr_cnt = 1'b0; #1;
        checks++; if (cnt_corr !== 16'd0 || cnt_corr2 !== 2'd0 || err_sticky !== 1'b0 || err_sticky2 !== 1'b0)
            begin errors++; $display("FAIL cnt_clr_wins: got %0d/%0d sticky %0b/%0b want 0/0 0/0", cnt_corr, cnt_corr2, err_sticky, err_sticky2); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cnt_clr_handshake: got out_valid=%0b want 0", out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_cw = '0; out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_clean();
        test_single_errors();
        test_invalid();
        test_backpressure();
        test_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
